divider: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU path.
//  It is the inverse of the shift/add multiplier and uses the same start/resp handshake.
//  The M-extension unit issues one operation, stalls, then takes quotient and remainder.
//  It selects one of the two results by funct3.

---
 rtl/divider_if.sv | 41 ++++
 rtl/divider.sv | 159 +++++++++++++++
 tb/tb_divider.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/response bundle between the M-extension unit and the divider
//
// Purpose: groups the divider's start/operand request and its result/response
//          signals so both sides connect through one port.
// Parameters:
//   WIDTH      operand/result width in bits
// Signals:
//   start      request, sampled only while the divider is idle
//   signed_op  1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   quotient   registered quotient
//   remainder  registered remainder
//   div_resp   one-cycle pulse: quotient/remainder valid
//   busy       divider is computing or presenting a result
// Modports:
//   master     requester side (M-extension unit)
//   slave      divider side

interface divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_resp;
  logic             busy;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quotient, remainder, div_resp, busy
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quotient, remainder, div_resp, busy
  );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: one quotient bit per clock on operand magnitudes, with sign fix-up
//          and the RISC-V divide-by-zero / signed-overflow results forced on the
//          final edge. Quotient and remainder are both returned; the requester
//          picks one by funct3.
// Parameters:
//   WIDTH      operand/result width in bits; also the iteration count
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        divider_if.slave (start, signed_op, dividend, divisor,
//              quotient, remainder, div_resp, busy)
// Optional feature:
//   DIV_FAST_PATH_EN  when defined, divide-by-zero, signed overflow and
//              divide-by-one complete on the accept edge instead of after
//              WIDTH iterations; results are identical either way.

module divider #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dq;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] pr;        // partial remainder; always < dvs between edges
  logic [CW-1:0]    count;
  logic             q_neg, r_neg;
  logic             special;   // divide-by-zero or signed overflow
  logic [WIDTH-1:0] spec_q, spec_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  // Accept-time decode of the request operands.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, ovf, acc_special;
  logic [WIDTH-1:0] acc_spec_q, acc_spec_r;
  logic             accept, last_iter;

  assign accept      = (state == IDLE) && bus.start;
  assign last_iter   = (state == CALC) && (count == LAST);
  assign a_neg       = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg       = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag       = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag       = b_neg ? -bus.divisor  : bus.divisor;
  assign div_zero    = (bus.divisor == '0);
  assign ovf         = bus.signed_op && (bus.dividend == INT_MIN) && (bus.divisor == '1);
  assign acc_special = div_zero | ovf;
  assign acc_spec_q  = div_zero ? '1 : bus.dividend;
  assign acc_spec_r  = div_zero ? bus.dividend : '0;

`ifdef DIV_FAST_PATH_EN
  // Divide-by-one shares the fast path: quotient is the dividend itself.
  logic             fast_hit;
  logic [WIDTH-1:0] fast_q, fast_r;
  assign fast_hit = acc_special | (bus.divisor == WIDTH'(1));
  assign fast_q   = acc_special ? acc_spec_q : bus.dividend;
  assign fast_r   = acc_special ? acc_spec_r : '0;
`endif

  // One restoring step. The trial subtract is WIDTH+1 bits wide so the shifted
  // partial remainder (up to 2*dvs-1) never overflows; a set top bit of the
  // difference is the borrow, meaning the divisor did not fit.
  logic [WIDTH:0]   pr_sh, diff;
  logic             fits;
  logic [WIDTH-1:0] pr_nx, dq_nx, q_fin, r_fin;

  assign pr_sh = {pr, dq[WIDTH-1]};
  assign diff  = pr_sh - {1'b0, dvs};
  assign fits  = ~diff[WIDTH];
  assign pr_nx = fits ? diff[WIDTH-1:0] : pr_sh[WIDTH-1:0];
  assign dq_nx = {dq[WIDTH-2:0], fits};
  assign q_fin = special ? spec_q : (q_neg ? -dq_nx : dq_nx);
  assign r_fin = special ? spec_r : (r_neg ? -pr_nx : pr_nx);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_FAST_PATH_EN
          state_nx = fast_hit ? DONE : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC:    if (count == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy     = (state == CALC) || (state == DONE);
    bus.div_resp = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq          <= '0;
      dvs         <= '0;
      pr          <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      special     <= 1'b0;
      spec_q      <= '0;
      spec_r      <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (accept) begin
      dq      <= a_mag;
      dvs     <= b_mag;
      pr      <= '0;
      count   <= '0;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      special <= acc_special;
      spec_q  <= acc_spec_q;
      spec_r  <= acc_spec_r;
`ifdef DIV_FAST_PATH_EN
      if (fast_hit) begin
        quotient_r  <= fast_q;
        remainder_r <= fast_r;
      end
`endif
    end else if (state == CALC) begin
      dq    <= dq_nx;
      pr    <= pr_nx;
      count <= count + CW'(1);
      if (last_iter) begin
        quotient_r  <= q_fin;
        remainder_r <= r_fin;
      end
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider

module tb_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  divider_if #(.WIDTH(32)) bus ();
  divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
    if (b == 32'd0 || b == 32'd1 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
`endif
    return 32;
  endfunction

  // Waits for div_resp, counting edges after the accept edge; assumes caller is #1 past an edge.
  task automatic wait_resp(input string tag, input int already, input int lat_exp);
    int lat;
    lat = already;
    while (!bus.div_resp && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q_exp, input logic [31:0] r_exp);
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_resp(tag, 0, exp_lat(s, a, b));
    check({tag, "_q"}, bus.quotient, q_exp);
    check({tag, "_r"}, bus.remainder, r_exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(bus.div_resp), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_hold_q"}, bus.quotient, q_exp);
  endtask

  initial begin
    int resp_seen;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_resp", 32'(bus.div_resp), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
    run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_op("rem_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);
    run_op("divu_5_7",    1'b0, 32'd5,          32'd7,          32'd0,          32'd5);
    run_op("div_5_0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
    run_op("div_m5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);
    run_op("divu_big_0",  1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);
    run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
    run_op("divu_min_m1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
    run_op("divu_x_1",    1'b0, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  32'd0);
    run_op("div_m9_1",    1'b1, 32'hFFFF_FFF7,  32'd1,          32'hFFFF_FFF7,  32'd0);
    run_op("divu_max_3",  1'b0, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0);

    // A second start during CALC, with new operands, must be dropped.
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_resp("ignore", 10, 32);
    check("ignore_q", bus.quotient, 32'd14);
    check("ignore_r", bus.remainder, 32'd2);
    @(posedge clk); #1;
    check("ignore_idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("ignore_not_queued", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-operation aborts it.
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_q", bus.quotient, 32'd0);
    check("abort_r", bus.remainder, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.div_resp) resp_seen++;
    end
    check("abort_no_resp", 32'(resp_seen), 32'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
